// File: rtl/maxnet_pkg.sv
// Shared types, default parameters and the saturation helper for the MAXNET engine.
package maxnet_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 32;
    localparam int DEF_FRAC     = 16;
    localparam int DEF_MAX_ITER = 255;

    // Working width of the saturation helper; wide enough for the full-precision
    // update expression at the largest legal N and any W up to 60.
    localparam int SAT_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SUM    = 3'd2,
        UPDATE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_to_w(input logic signed [SAT_W-1:0] x,
                                                         input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/maxnet_update_unit.sv
// Combinational lateral-inhibition step for one channel:
// a_o = relu(sat_W(a_i - ((eps_i * (sum_i - a_i)) >>> FRAC))).
module maxnet_update_unit
    import maxnet_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC,
    parameter int SW   = DEF_W + 2
) (
    input  logic signed [W-1:0]  a_i,
    input  logic signed [SW-1:0] sum_i,
    input  logic signed [W-1:0]  eps_i,
    output logic signed [W-1:0]  a_o
);

    localparam int DW = SW + 1;   // difference S - a_i never overflows
    localparam int PW = W + DW;   // full-precision product width

    logic signed [DW-1:0]    diff;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    shifted;
    logic signed [PW:0]      raw;
    logic signed [SAT_W-1:0] sat;
    logic                    unused_sat_hi;

    // Multiply, arithmetic shift, subtract, saturate, then clamp negatives to zero.
    always_comb begin
        diff          = DW'(sum_i) - DW'(a_i);
        prod          = PW'(eps_i) * PW'(diff);
        shifted       = prod >>> FRAC;
        raw           = (PW + 1)'(a_i) - (PW + 1)'(shifted);
        sat           = sat_to_w(SAT_W'(raw), W);
        unused_sat_hi = ^sat[SAT_W-1:W];
        // A negative raw value saturates to a negative word, so its sign decides relu.
        a_o           = raw[PW] ? '0 : sat[W-1:0];
    end

endmodule

// File: rtl/maxnet_engine.sv
// MAXNET winner-take-all engine: loads N activations, then iterates
// sum / sequential update / check until at most one channel survives or the
// iteration limit is hit. One shared update unit is time-multiplexed.
//
// Request semantics: start is a one-shot request with no ready; it is accepted
// on any rising edge where the engine sits in IDLE or DONE and ignored otherwise.
// busy (high LOAD..CHECK) tells the requester whether a start would be dropped.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int FRAC     = DEF_FRAC,
    parameter int MAX_ITER = DEF_MAX_ITER,
    localparam int IW      = $clog2(N),
    localparam int SW      = W + IW,
    localparam int CW      = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*W-1:0]  a_init,
    input  logic [W-1:0]   epsilon,
    output logic            busy,
    output logic            done,
    output logic            winner_valid,
    output logic [IW-1:0]   winner_idx,
    output logic [W-1:0]   winner_val,
    output logic [7:0]      iter_count,
    output logic            timeout,
    output state_t          dbg_state
);

    state_t               state_q, state_d;
    logic [IW-1:0]        ch_q, ch_d;
    logic signed [W-1:0]  a_q [N];
    logic signed [W-1:0]  a_d [N];
    logic signed [W-1:0]  eps_q, eps_d;
    logic signed [SW-1:0] acc_q, acc_d;
    logic [CW-1:0]        nz_q, nz_d;
    logic [IW-1:0]        last_idx_q, last_idx_d;
    logic signed [W-1:0]  last_val_q, last_val_d;
    logic [7:0]           iter_q, iter_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wv_q, wv_d;
    logic [IW-1:0]        widx_q, widx_d;
    logic [W-1:0]         wval_q, wval_d;
    logic                 to_q, to_d;

    logic signed [W-1:0]  ld_val [N];
    logic [CW-1:0]        ld_cnt;
    logic [IW-1:0]        ld_idx;
    logic signed [W-1:0]  ld_v;
    logic signed [W-1:0]  upd_val;

    maxnet_update_unit #(
        .W    (W),
        .FRAC (FRAC),
        .SW   (SW)
    ) u_update (
        .a_i   (a_q[ch_q]),
        .sum_i (acc_q),
        .eps_i (eps_q),
        .a_o   (upd_val)
    );

    // Clamp the incoming activations and find how many survive the load.
    always_comb begin
        ld_cnt = '0;
        ld_idx = '0;
        ld_v   = '0;
        for (int i = 0; i < N; i++) begin
            ld_val[i] = a_init[i*W +: W];
            if (ld_val[i][W-1]) begin
                ld_val[i] = '0;
            end
            if (ld_val[i] != '0) begin
                ld_cnt = ld_cnt + 1'b1;
                ld_idx = IW'(i);
                ld_v   = ld_val[i];
            end
        end
    end

    // Next-state and datapath updates for the load / sum / update / check loop.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        a_d        = a_q;
        eps_d      = eps_q;
        acc_d      = acc_q;
        nz_d       = nz_q;
        last_idx_d = last_idx_q;
        last_val_d = last_val_q;
        iter_d     = iter_q;
        wv_d       = wv_q;
        widx_d     = widx_q;
        wval_d     = wval_q;
        to_d       = to_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < N; i++) begin
                    a_d[i] = ld_val[i];
                end
                eps_d  = epsilon;
                iter_d = '0;
                wv_d   = 1'b0;
                to_d   = 1'b0;
                widx_d = '0;
                wval_d = '0;
                ch_d   = '0;
                acc_d  = '0;
                if (ld_cnt <= CW'(1)) begin
                    state_d = DONE;
                    if (ld_cnt == CW'(1)) begin
                        wv_d   = 1'b1;
                        widx_d = ld_idx;
                        wval_d = ld_v;
                    end
                end else begin
                    state_d = SUM;
                end
            end
            SUM: begin
                acc_d = acc_q + SW'(a_q[ch_q]);
                if (ch_q == IW'(N - 1)) begin
                    ch_d    = '0;
                    nz_d    = '0;
                    state_d = UPDATE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            UPDATE: begin
                // S stays frozen in acc_q and each channel only reads itself,
                // so in-place writes still see pre-update values.
                a_d[ch_q] = upd_val;
                if (upd_val != '0) begin
                    nz_d       = nz_q + 1'b1;
                    last_idx_d = ch_q;
                    last_val_d = upd_val;
                end
                if (ch_q == IW'(N - 1)) begin
                    ch_d    = '0;
                    iter_d  = iter_q + 8'd1;
                    state_d = CHECK;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            CHECK: begin
                if (nz_q <= CW'(1) || iter_q == 8'(MAX_ITER)) begin
                    state_d = DONE;
                    if (nz_q == CW'(1)) begin
                        wv_d   = 1'b1;
                        widx_d = last_idx_q;
                        wval_d = last_val_q;
                    end else if (nz_q > CW'(1)) begin
                        to_d = 1'b1;
                    end
                end else begin
                    acc_d   = '0;
                    state_d = SUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD) || (state_d == SUM) ||
                 (state_d == UPDATE) || (state_d == CHECK);
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            a_q        <= '{default: '0};
            eps_q      <= '0;
            acc_q      <= '0;
            nz_q       <= '0;
            last_idx_q <= '0;
            last_val_q <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wv_q       <= 1'b0;
            widx_q     <= '0;
            wval_q     <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            a_q        <= a_d;
            eps_q      <= eps_d;
            acc_q      <= acc_d;
            nz_q       <= nz_d;
            last_idx_q <= last_idx_d;
            last_val_q <= last_val_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wv_q       <= wv_d;
            widx_q     <= widx_d;
            wval_q     <= wval_d;
            to_q       <= to_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign winner_valid = wv_q;
    assign winner_idx   = widx_q;
    assign winner_val   = wval_q;
    assign iter_count   = iter_q;
    assign timeout      = to_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine: a default instance (MAX_ITER=255)
// and a MAX_ITER=3 instance share all inputs; a reference model pushes the
// expected result of every run into a per-instance queue, and a monitor pops
// and compares on each done pulse.
module tb_maxnet_engine;
    import maxnet_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic          wv;
        logic [IW-1:0] idx;
        logic [W-1:0]  val;
        logic [7:0]    iter;
        logic          to;
        logic [15:0]   cyc;
    } result_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N*W-1:0] a_init;
    logic [W-1:0]   epsilon;

    logic           busy_a, done_a, wv_a, to_a;
    logic [IW-1:0]  idx_a;
    logic [W-1:0]   val_a;
    logic [7:0]     iter_a;
    state_t         st_a;
    logic           busy_b, done_b, wv_b, to_b;
    logic [IW-1:0]  idx_b;
    logic [W-1:0]   val_b;
    logic [7:0]     iter_b;
    state_t         st_b;

    result_t        exp_q [2][$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc_cnt  = 0;
    int             start_cyc = 0;
    int             last_cyc [2];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    maxnet_engine u_dut_a (
        .clk (clk), .rst (rst), .start (start), .a_init (a_init), .epsilon (epsilon),
        .busy (busy_a), .done (done_a), .winner_valid (wv_a), .winner_idx (idx_a),
        .winner_val (val_a), .iter_count (iter_a), .timeout (to_a), .dbg_state (st_a)
    );

    maxnet_engine #(.MAX_ITER(3)) u_dut_b (
        .clk (clk), .rst (rst), .start (start), .a_init (a_init), .epsilon (epsilon),
        .busy (busy_b), .done (done_b), .winner_valid (wv_b), .winner_idx (idx_b),
        .winner_val (val_b), .iter_count (iter_b), .timeout (to_b), .dbg_state (st_b)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Plain fixed-point reference of the algorithm, 128-bit arithmetic.
    function automatic result_t model(input logic [N*W-1:0] ai, input logic [W-1:0] ep,
                                      input int max_iter);
        logic signed [127:0] a [N];
        logic signed [127:0] s, e, t, hi, lo;
        int nz, it, last;
        result_t r;
        hi = (128'sd1 <<< (W - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        e  = 128'($signed(ep));
        nz = 0;
        last = 0;
        for (int i = 0; i < N; i++) begin
            a[i] = 128'($signed(ai[i*W +: W]));
            if (a[i] < 0) a[i] = '0;
            if (a[i] != 0) begin nz++; last = i; end
        end
        it = 0;
        while (nz > 1 && it < max_iter) begin
            s = '0;
            for (int i = 0; i < N; i++) s = s + a[i];
            nz = 0;
            for (int i = 0; i < N; i++) begin
                t = a[i] - ((e * (s - a[i])) >>> 16);
                if (t > hi) t = hi;
                if (t < lo) t = lo;
                if (t < 0) t = '0;
                a[i] = t;
                if (t != 0) begin nz++; last = i; end
            end
            it++;
        end
        r.wv   = (nz == 1);
        r.idx  = (nz == 1) ? IW'(last) : '0;
        r.val  = (nz == 1) ? W'(a[last]) : '0;
        r.iter = 8'(it);
        r.to   = (nz > 1);
        r.cyc  = 16'(2 + 9 * it);
        return r;
    endfunction

    task automatic score(input int d, input logic dn, input logic bz, input result_t got);
        result_t e;
        if (dn !== 1'b1) return;
        last_cyc[d] = int'(got.cyc);
        if (exp_q[d].size() == 0) begin
            check($sformatf("d%0d_unexpected_done", d), 64'(1), 64'(0));
            return;
        end
        e = exp_q[d].pop_front();
        check($sformatf("d%0d_winner_valid", d), 64'(got.wv), 64'(e.wv));
        check($sformatf("d%0d_winner_idx", d), 64'(got.idx), 64'(e.idx));
        check($sformatf("d%0d_winner_val", d), 64'(got.val), 64'(e.val));
        check($sformatf("d%0d_iter_count", d), 64'(got.iter), 64'(e.iter));
        check($sformatf("d%0d_timeout", d), 64'(got.to), 64'(e.to));
        check($sformatf("d%0d_done_latency", d), 64'(got.cyc), 64'(e.cyc));
        check($sformatf("d%0d_busy_at_done", d), 64'(bz), 64'(0));
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic pend [2];
        result_t ga, gb;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            if (pend[0]) check("d0_done_width", 64'(done_a), 64'(0));
            if (pend[1]) check("d1_done_width", 64'(done_b), 64'(0));
            pend[0] = (done_a === 1'b1);
            pend[1] = (done_b === 1'b1);
            ga = '{wv: wv_a, idx: idx_a, val: val_a, iter: iter_a, to: to_a,
                   cyc: 16'(cyc_cnt - start_cyc)};
            gb = '{wv: wv_b, idx: idx_b, val: val_b, iter: iter_b, to: to_b,
                   cyc: 16'(cyc_cnt - start_cyc)};
            score(0, done_a, busy_a, ga);
            score(1, done_b, busy_b, gb);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        a_init  = '0;
        epsilon = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run(input logic [N*W-1:0] ai, input logic [W-1:0] ep, input bit push,
                             output result_t ra, output result_t rb);
        @(negedge clk);
        a_init    = ai;
        epsilon   = ep;
        start     = 1'b1;
        start_cyc = cyc_cnt;
        ra = model(ai, ep, 255);
        rb = model(ai, ep, 3);
        if (push) begin
            exp_q[0].push_back(ra);
            exp_q[1].push_back(rb);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            check("wait_done_timeout", 64'(0), 64'(1));
            exp_q[0].delete();
            exp_q[1].delete();
            do_reset();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_held(input result_t ra, input result_t rb);
        check("held_a_valid", 64'(wv_a), 64'(ra.wv));
        check("held_a_idx", 64'(idx_a), 64'(ra.idx));
        check("held_a_val", 64'(val_a), 64'(ra.val));
        check("held_a_timeout", 64'(to_a), 64'(ra.to));
        check("held_b_valid", 64'(wv_b), 64'(rb.wv));
        check("held_b_iter", 64'(iter_b), 64'(rb.iter));
        check("held_a_state", 64'(st_a), 64'(DONE));
    endtask

    task automatic run_case(input logic [N*W-1:0] ai, input logic [W-1:0] ep,
                            output result_t ra, output result_t rb);
        start_run(ai, ep, 1'b1, ra, rb);
        wait_idle();
        check_held(ra, rb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        result_t ra, rb;
        logic [N*W-1:0] saved;
        do_reset();

        // Reset state of both instances.
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        check("rst_valid", 64'(wv_a), 64'(0));
        check("rst_idx", 64'(idx_a), 64'(0));
        check("rst_val", 64'(val_a), 64'(0));
        check("rst_iter", 64'(iter_a), 64'(0));
        check("rst_timeout", 64'(to_a), 64'(0));
        check("rst_state", 64'(st_a), 64'(IDLE));
        check("rst_b_state", 64'(st_b), 64'(IDLE));

        // Clear winner among 0.2/0.4/0.6/0.8 with epsilon 0.2.
        run_case(pack4(13107, 26214, 39321, 52428), 32'd13107, ra, rb);
        check("c1_valid", 64'(wv_a), 64'(1));
        check("c1_idx", 64'(idx_a), 64'(3));
        check("c1_val_nonzero", 64'(val_a != 0), 64'(1));
        check("c1_timeout", 64'(to_a), 64'(0));

        // Equal inputs with epsilon 0.5 all die in one iteration.
        run_case(pack4(32768, 32768, 32768, 32768), 32'd32768, ra, rb);
        check("c2_valid", 64'(wv_a), 64'(0));
        check("c2_iter", 64'(iter_a), 64'(1));
        check("c2_latency", 64'(last_cyc[0]), 64'(11));

        // Single positive channel after clamping: straight to DONE.
        run_case(pack4(0, 0, 45875, -19661), 32'd13107, ra, rb);
        check("c3_valid", 64'(wv_a), 64'(1));
        check("c3_idx", 64'(idx_a), 64'(2));
        check("c3_val", 64'(val_a), 64'(45875));
        check("c3_iter", 64'(iter_a), 64'(0));
        check("c3_latency", 64'(last_cyc[0]), 64'(2));

        // Nothing positive at load.
        run_case(pack4(0, -6554, 0, 0), 32'd13107, ra, rb);
        check("c4_valid", 64'(wv_a), 64'(0));
        check("c4_iter", 64'(iter_a), 64'(0));

        // Zero inhibition: iteration limit is the only way out.
        run_case(pack4(6554, 13107, 19661, 26214), 32'd0, ra, rb);
        check("c5_b_timeout", 64'(to_b), 64'(1));
        check("c5_b_iter", 64'(iter_b), 64'(3));
        check("c5_b_valid", 64'(wv_b), 64'(0));
        check("c5_a_timeout", 64'(to_a), 64'(1));
        check("c5_a_iter", 64'(iter_a), 64'(255));

        // Tie never yields a winner.
        run_case(pack4(32768, 32768, 0, 0), 32'd6554, ra, rb);
        check("c6_tie_valid_a", 64'(wv_a), 64'(0));
        check("c6_tie_valid_b", 64'(wv_b), 64'(0));

        // Reset during the second SUM phase, with start held alongside reset.
        start_run(pack4(13107, 26214, 39321, 52428), 32'd13107, 1'b0, ra, rb);
        repeat (11) @(negedge clk);
        check("c7_in_sum2", 64'(st_a), 64'(SUM));
        rst = 1'b1;
        @(negedge clk);
        check("c7_rst_busy", 64'(busy_a), 64'(0));
        check("c7_rst_valid", 64'(wv_a), 64'(0));
        check("c7_rst_idx", 64'(idx_a), 64'(0));
        check("c7_rst_val", 64'(val_a), 64'(0));
        check("c7_rst_iter", 64'(iter_a), 64'(0));
        check("c7_rst_done", 64'(done_a), 64'(0));
        start = 1'b1;
        @(negedge clk);
        check("c7_rst_priority", 64'(st_a), 64'(IDLE));
        check("c7_rst_priority_busy", 64'(busy_a), 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("c7_idle_after", 64'(st_a), 64'(IDLE));
        run_case(pack4(13107, 26214, 39321, 52428), 32'd13107, ra, rb);
        check("c7_restart_idx", 64'(idx_a), 64'(3));

        // Start pulsed mid-run with different data must be ignored.
        start_run(pack4(13107, 26214, 39321, 52428), 32'd13107, 1'b1, ra, rb);
        repeat (4) @(negedge clk);
        check("c8_busy_mid", 64'(busy_a), 64'(1));
        saved  = a_init;
        a_init = pack4(65536, 0, 0, 0);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a_init = saved;
        wait_idle();
        check_held(ra, rb);

        // Random activations and inhibition weights.
        for (int k = 0; k < 4; k++) begin
            int v [N];
            for (int i = 0; i < N; i++) v[i] = int'($urandom_range(78643, 0)) - 13107;
            run_case(pack4(v[0], v[1], v[2], v[3]), 32'($urandom_range(39321, 6554)), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
